// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port data memory between two MEM-stage slots,
// serialising dual accesses in program order with a one-cycle stall.
module dmem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd1_MEM,
  input  logic              wr1_MEM,
  input  logic [31:0]       addr1_MEM,
  input  logic [DATA_W-1:0] wdata1_MEM,
  input  logic              rd2_MEM,
  input  logic              wr2_MEM,
  input  logic [31:0]       addr2_MEM,
  input  logic [DATA_W-1:0] wdata2_MEM,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              stall,
  output logic [DATA_W-1:0] rdata1_WB,
  output logic [DATA_W-1:0] rdata2_WB,
  output logic [CNT_W-1:0]  conflict_cnt
);
  typedef enum logic {IDLE, SECOND} state_e;
  state_e              state_q, state_d;
  logic                h_rd_q, h_rd_d, h_wr_q, h_wr_d;
  logic [ADDR_W-1:0]   h_addr_q, h_addr_d;
  logic [DATA_W-1:0]   h_wdata_q, h_wdata_d, hold1_q, hold1_d;
  logic                hold1_valid_q, hold1_valid_d;
  logic [1:0]          last_sel_q, last_sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req1, req2, both, second;
  logic                s_rd, s_wr;
  logic                unused;
  assign req1   = rd1_MEM | wr1_MEM;
  assign req2   = rd2_MEM | wr2_MEM;
  assign both   = req1 & req2;
  assign second = state_q == SECOND;
  assign unused = ^{addr1_MEM[31:ADDR_W], addr2_MEM[31:ADDR_W], last_sel_q};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      h_rd_q        <= 1'b0;
      h_wr_q        <= 1'b0;
      h_addr_q      <= '0;
      h_wdata_q     <= '0;
      hold1_q       <= '0;
      hold1_valid_q <= 1'b0;
      last_sel_q    <= 2'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      h_rd_q        <= h_rd_d;
      h_wr_q        <= h_wr_d;
      h_addr_q      <= h_addr_d;
      h_wdata_q     <= h_wdata_d;
      hold1_q       <= hold1_d;
      hold1_valid_q <= hold1_valid_d;
      last_sel_q    <= last_sel_d;
      cnt_q         <= cnt_d;
    end
  end
  always_comb begin
    state_d       = second ? IDLE : (both ? SECOND : IDLE);
    h_rd_d        = h_rd_q;
    h_wr_d        = h_wr_q;
    h_addr_d      = h_addr_q;
    h_wdata_d     = h_wdata_q;
    hold1_d       = second ? mem_rdata : hold1_q;
    hold1_valid_d = second;
    last_sel_d    = second ? 2'd2 : (req1 ? 2'd1 : (req2 ? 2'd2 : last_sel_q));
    cnt_d         = cnt_q;
    if (!second && both) begin
      h_rd_d    = rd2_MEM;
      h_wr_d    = wr2_MEM;
      h_addr_d  = addr2_MEM[ADDR_W-1:0];
      h_wdata_d = wdata2_MEM;
      cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end
  end
  // Slot 1 wins whenever it requests in IDLE; SECOND replays the latched slot 2 copy.
  always_comb begin
    s_rd      = second ? h_rd_q    : (req1 ? rd1_MEM    : rd2_MEM);
    s_wr      = second ? h_wr_q    : (req1 ? wr1_MEM    : wr2_MEM);
    mem_addr  = second ? h_addr_q  : (req1 ? addr1_MEM[ADDR_W-1:0] : addr2_MEM[ADDR_W-1:0]);
    mem_wdata = second ? h_wdata_q : (req1 ? wdata1_MEM : wdata2_MEM);
    mem_we    = rst & s_wr;
    mem_re    = rst & s_rd & ~s_wr;
    stall     = rst & ~second & both;
  end
  assign rdata1_WB    = hold1_valid_q ? hold1_q : mem_rdata;
  assign rdata2_WB    = mem_rdata;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus with a program-order access model checked every cycle.
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst, mem_ld;
  logic        rd1_MEM, wr1_MEM, rd2_MEM, wr2_MEM;
  logic [31:0] addr1_MEM, addr2_MEM, wdata1_MEM, wdata2_MEM;
  logic [31:0] mem_rdata;
  logic [9:0]  mem_addr, s_addr;
  logic [31:0] mem_wdata, s_wdata, rdata1_WB, rdata2_WB, s_r1, s_r2;
  logic        mem_we, mem_re, stall, s_we, s_re, s_stall;
  logic [15:0] conflict_cnt;
  logic [1:0]  cnt2;
  logic [31:0] mem [1024];
  logic [31:0] model_mem [1024];
  logic [7:0]  hist;
  int          checks = 0, failures = 0;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .rd1_MEM(rd1_MEM), .wr1_MEM(wr1_MEM), .addr1_MEM(addr1_MEM), .wdata1_MEM(wdata1_MEM),
    .rd2_MEM(rd2_MEM), .wr2_MEM(wr2_MEM), .addr2_MEM(addr2_MEM), .wdata2_MEM(wdata2_MEM),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .stall(stall),
    .rdata1_WB(rdata1_WB), .rdata2_WB(rdata2_WB), .conflict_cnt(conflict_cnt)
  );

  dmem_port_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .rd1_MEM(rd1_MEM), .wr1_MEM(wr1_MEM), .addr1_MEM(addr1_MEM), .wdata1_MEM(wdata1_MEM),
    .rd2_MEM(rd2_MEM), .wr2_MEM(wr2_MEM), .addr2_MEM(addr2_MEM), .wdata2_MEM(wdata2_MEM),
    .mem_rdata(mem_rdata), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .mem_we(s_we), .mem_re(s_re), .stall(s_stall),
    .rdata1_WB(s_r1), .rdata2_WB(s_r2), .conflict_cnt(cnt2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 3) ? 32'h11 : (i == 4) ? 32'h22 : (i == 5) ? 32'hAAAA0001 : (32'hC0DE0000 ^ i);
  endfunction

  always @(posedge clk) begin
    if (mem_ld) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each access is applied to model_mem in program order; results appear the cycle after the pair completes.
  task automatic acc(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d,
                     output logic [31:0] v);
    cmp("mem_we", {31'b0, mem_we}, {31'b0, wr});
    cmp("mem_re", {31'b0, mem_re}, {31'b0, rd & ~wr});
    if (rd | wr) cmp("mem_addr", {22'b0, mem_addr}, {22'b0, a});
    if (wr) begin
      cmp("mem_wdata", mem_wdata, d);
      model_mem[a] = d;
    end
    v = model_mem[a];
  endtask

  task automatic checker_loop();
    bit          pend = 0, p1c = 0, n1c = 0, n2c = 0, c1c, c2c;
    logic        p_rd = 0, p_wr = 0;
    logic [9:0]  p_a = 0;
    logic [31:0] p_d = 0, p1v = 0, n1v = 0, n2v = 0, c1v, c2v, v;
    int          ec = 0, ec2 = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cmp("rst_stall", {31'b0, stall}, 32'd0);
        cmp("rst_we", {31'b0, mem_we}, 32'd0);
        cmp("rst_re", {31'b0, mem_re}, 32'd0);
        pend = 0; n1c = 0; n2c = 0; ec = 0; ec2 = 0;
      end else begin
        c1c = n1c; c1v = n1v; c2c = n2c; c2v = n2v; n1c = 0; n2c = 0;
        if (c1c) cmp("rdata1_WB", rdata1_WB, c1v);
        if (c2c) cmp("rdata2_WB", rdata2_WB, c2v);
        cmp("conflict_cnt", {16'b0, conflict_cnt}, ec);
        cmp("conflict_cnt_w2", {30'b0, cnt2}, ec2);
        if (pend) begin
          cmp("stall", {31'b0, stall}, 32'd0);
          acc(p_rd, p_wr, p_a, p_d, v);
          pend = 0; n1c = p1c; n1v = p1v; n2c = p_rd & ~p_wr; n2v = v;
        end else if ((rd1_MEM | wr1_MEM) && (rd2_MEM | wr2_MEM)) begin
          cmp("stall", {31'b0, stall}, 32'd1);
          acc(rd1_MEM, wr1_MEM, addr1_MEM[9:0], wdata1_MEM, v);
          p1c = rd1_MEM & ~wr1_MEM; p1v = v; pend = 1;
          p_rd = rd2_MEM; p_wr = wr2_MEM; p_a = addr2_MEM[9:0]; p_d = wdata2_MEM;
          if (ec < 65535) ec++;
          if (ec2 < 3) ec2++;
        end else if (rd1_MEM | wr1_MEM) begin
          cmp("stall", {31'b0, stall}, 32'd0);
          acc(rd1_MEM, wr1_MEM, addr1_MEM[9:0], wdata1_MEM, v);
          n1c = rd1_MEM & ~wr1_MEM; n1v = v;
        end else begin
          cmp("stall", {31'b0, stall}, 32'd0);
          acc(rd2_MEM, wr2_MEM, addr2_MEM[9:0], wdata2_MEM, v);
          n2c = rd2_MEM & ~wr2_MEM; n2v = v;
        end
      end
    end
  endtask

  task automatic drive(input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic r2, input logic w2, input logic [31:0] a2, input logic [31:0] d2);
    rd1_MEM = r1; wr1_MEM = w1; addr1_MEM = a1; wdata1_MEM = d1;
    rd2_MEM = r2; wr2_MEM = w2; addr2_MEM = a2; wdata2_MEM = d2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Issues one instruction pair; on a conflict, slot 2 address/data are scrambled during the replay cycle.
  task automatic pair(input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic r2, input logic w2, input logic [31:0] a2, input logic [31:0] d2);
    drive(r1, w1, a1, d1, r2, w2, a2, d2);
    @(negedge clk);
    hist = {hist[6:0], stall};
    step();
    if ((r1 | w1) && (r2 | w2)) begin
      addr2_MEM = ~a2; wdata2_MEM = ~d2;
      @(negedge clk);
      hist = {hist[6:0], stall};
      step();
    end
  endtask

  initial begin
    rst = 1'b0; mem_ld = 1'b1; hist = '0;
    idle();
    for (int i = 0; i < 1024; i++) model_mem[i] = init_val(i);
    fork checker_loop(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset_stall", {31'b0, stall}, 32'd0);
    cmp("reset_cnt", {16'b0, conflict_cnt}, 32'd0);
    cmp("reset_we", {31'b0, mem_we}, 32'd0);
    step();
    rst = 1'b1; mem_ld = 1'b0;
    step();
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("single_re", {31'b0, mem_re}, 32'd1);
    cmp("single_addr", {22'b0, mem_addr}, 32'd5);
    cmp("single_stall", {31'b0, stall}, 32'd0);
    step(); idle();
    @(negedge clk);
    cmp("single_rdata1", rdata1_WB, 32'hAAAA0001);
    cmp("single_cnt", {16'b0, conflict_cnt}, 32'd0);
    step();
    drive(1, 0, 3, 0, 1, 0, 4, 0);
    @(negedge clk);
    cmp("dual_c0_stall", {31'b0, stall}, 32'd1);
    cmp("dual_c0_addr", {22'b0, mem_addr}, 32'd3);
    step();
    @(negedge clk);
    cmp("dual_c1_stall", {31'b0, stall}, 32'd0);
    cmp("dual_c1_addr", {22'b0, mem_addr}, 32'd4);
    step(); idle();
    @(negedge clk);
    cmp("dual_rdata1", rdata1_WB, 32'h11);
    cmp("dual_rdata2", rdata2_WB, 32'h22);
    cmp("dual_cnt", {16'b0, conflict_cnt}, 32'd1);
    step();
    hist = '0;
    pair(0, 1, 7, 32'hDEAD, 1, 0, 7, 0); idle();
    @(negedge clk);
    cmp("st1_ld2_rdata2", rdata2_WB, 32'hDEAD);
    cmp("st1_ld2_stalls", {24'b0, hist}, 32'b10);
    step();
    pair(0, 1, 9, 1, 0, 1, 9, 2); idle();
    @(negedge clk);
    cmp("st1_st2_mem9", mem[9], 32'd2);
    step();
    hist = '0;
    pair(1, 0, 3, 0, 1, 0, 4, 0);
    cmp("cnt_after4", {16'b0, conflict_cnt}, 32'd4);
    cmp("cnt_w2_sat4", {30'b0, cnt2}, 32'd3);
    pair(1, 0, 5, 0, 1, 0, 9, 0);
    pair(0, 1, 40, 32'h4040, 1, 0, 40, 0);
    idle();
    @(negedge clk);
    cmp("b2b_stall_pattern", {24'b0, hist}, 32'b101010);
    cmp("b2b_cnt", {16'b0, conflict_cnt}, 32'd6);
    cmp("b2b_cnt_w2", {30'b0, cnt2}, 32'd3);
    step();
    pair(0, 0, 0, 0, 0, 1, 30, 32'h1234); idle(); step();
    pair(1, 0, 30, 0, 0, 0, 0, 0); idle(); step();
    pair(1, 1, 31, 32'h99, 1, 0, 31, 0); idle(); step();
    pair(1, 0, 7, 0, 0, 1, 7, 32'hBEEF); idle();
    @(negedge clk);
    cmp("ld1_st2_old", rdata1_WB, 32'hDEAD);
    step();
    pair(0, 0, 0, 0, 1, 0, 9, 0); idle(); step();
    pair(1, 0, 7, 0, 0, 0, 0, 0); idle(); step();
    pair(0, 1, 60, 32'h5, 1, 1, 61, 32'h6); idle(); step();
    drive(0, 1, 20, 32'h55, 0, 1, 21, 32'h77);
    step();
    rst = 1'b0;
    #1;
    cmp("rst_second_stall", {31'b0, stall}, 32'd0);
    cmp("rst_second_we", {31'b0, mem_we}, 32'd0);
    cmp("rst_second_re", {31'b0, mem_re}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; idle();
    @(negedge clk);
    cmp("rst_cnt", {16'b0, conflict_cnt}, 32'd0);
    cmp("rst_cnt_w2", {30'b0, cnt2}, 32'd0);
    cmp("rst_mem20", mem[20], 32'h55);
    cmp("rst_mem21_kept", mem[21], init_val(21));
    step();
    pair(0, 0, 0, 0, 1, 0, 21, 0); idle(); step();
    pair(1, 0, 3, 0, 0, 0, 0, 0); idle();
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
